// File: rtl/padding_pkg.sv
// Shared types for the padding writer: FSM state encoding, latched
// configuration bundle and the configuration legality check.
// The cfg bundle field widths follow the package defaults; the top-level
// parameters default to the same values.
package padding_pkg;

    localparam int unsigned PKG_PE     = 16;
    localparam int unsigned PKG_ADDR_W = 32;
    localparam int unsigned PKG_DIM_W  = 10;
    localparam int unsigned PKG_PAD_W  = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TOP_PAD   = 3'd1,
        ROW_LEFT  = 3'd2,
        ROW_DATA  = 3'd3,
        ROW_RIGHT = 3'd4,
        BOT_PAD   = 3'd5
    } pad_state_t;

    typedef struct packed {
        logic [PKG_DIM_W-1:0]  c;
        logic [PKG_DIM_W-1:0]  w;
        logic [PKG_DIM_W-1:0]  h;
        logic [PKG_PAD_W-1:0]  pt;
        logic [PKG_PAD_W-1:0]  pb;
        logic [PKG_PAD_W-1:0]  pl;
        logic [PKG_PAD_W-1:0]  pr;
        logic [7:0]            pad_val;
        logic [PKG_ADDR_W-1:0] base;
    } pad_cfg_t;

    // Non-empty map with a channel count that fills whole words.
    function automatic logic legal_cfg(input pad_cfg_t cfg, input int unsigned pe);
        return (cfg.c != '0) && (cfg.w != '0) && (cfg.h != '0) &&
               ((32'(cfg.c) % pe) == 32'd0);
    endfunction

endpackage

// File: rtl/pad_raster_cnt.sv
// Nested raster position counter over the padded frame.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr_i         restart at position (0,0,0)
//   adv_i         step to the next word (k innermost, then x, then y)
//   wpp_i/pw_i/ph_i  words per pixel, padded width, padded height
//   x_o, y_o      current column / row
//   eog_o         current word is the last word of its pixel
//   eor_o         current word is the last word of its padded row
//   eof_o         current word is the last word of the frame
module pad_raster_cnt #(
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic [CNT_W-1:0] wpp_i,
    input  logic [CNT_W-1:0] pw_i,
    input  logic [CNT_W-1:0] ph_i,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o,
    output logic             eog_o,
    output logic             eor_o,
    output logic             eof_o
);

    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;

    // End-of-group flags, each qualified by the inner ones.
    assign eog_o = (k_q == wpp_i - CNT_W'(1));
    assign eor_o = eog_o && (x_q == pw_i - CNT_W'(1));
    assign eof_o = eor_o && (y_q == ph_i - CNT_W'(1));
    assign x_o   = x_q;
    assign y_o   = y_q;

    // Next position.
    always_comb begin
        k_d = k_q;
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            k_d = '0;
            x_d = '0;
            y_d = '0;
        end else if (adv_i) begin
            if (!eog_o) begin
                k_d = k_q + CNT_W'(1);
            end else begin
                k_d = '0;
                if (!eor_o) begin
                    x_d = x_q + CNT_W'(1);
                end else begin
                    x_d = '0;
                    y_d = eof_o ? '0 : y_q + CNT_W'(1);
                end
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
            x_q <= '0;
            y_q <= '0;
        end else begin
            k_q <= k_d;
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/padding_writer_v2.sv
// Zero-point padding writer: consumes a raster stream of un-padded OFM words
// and writes the padded feature map to contiguous buffer addresses.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, cfg_*                start pulse and configuration latched by it
//   in_valid/in_ready/in_data   input word stream (in_ready combinational)
//   wr_en/wr_addr/wr_data       registered buffer write port
//   row_done/row_idx            pulse with last write of each padded row
//   busy, done, cfg_err         status: frame active, final write, bad config
module padding_writer_v2
    import padding_pkg::*;
#(
    parameter int unsigned PE     = PKG_PE,
    parameter int unsigned ADDR_W = PKG_ADDR_W,
    parameter int unsigned DIM_W  = PKG_DIM_W,
    parameter int unsigned PAD_W  = PKG_PAD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_c,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [PAD_W-1:0]  cfg_pt,
    input  logic [PAD_W-1:0]  cfg_pb,
    input  logic [PAD_W-1:0]  cfg_pl,
    input  logic [PAD_W-1:0]  cfg_pr,
    input  logic [7:0]        cfg_pad_val,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PE*8-1:0]   in_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PE*8-1:0]   wr_data,
    output logic              row_done,
    output logic [DIM_W-1:0]  row_idx,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam int unsigned DATA_W = PE * 8;
    localparam int unsigned CNT_W  = DIM_W + 1;

    pad_cfg_t   cfg_in;
    pad_cfg_t   cfg_q;
    pad_state_t state_q, state_d;
    pad_state_t row_start;

    logic              in_legal;
    logic              launch;
    logic              is_pad;
    logic              adv;
    logic [CNT_W-1:0]  wpp, pw, ph;
    logic [CNT_W-1:0]  data_x_beg, data_x_end, data_y_end;
    logic [CNT_W-1:0]  x, y, x_nxt, y_nxt;
    logic              eog, eor, eof;
    logic [ADDR_W-1:0] idx_q;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              row_done_q;
    logic [DIM_W-1:0]  row_idx_q;
    logic              done_q;
    logic              cfg_err_q;

    // Bundle the live cfg inputs for the legality check and the start latch.
    always_comb begin
        cfg_in         = '0;
        cfg_in.c       = PKG_DIM_W'(cfg_c);
        cfg_in.w       = PKG_DIM_W'(cfg_w);
        cfg_in.h       = PKG_DIM_W'(cfg_h);
        cfg_in.pt      = PKG_PAD_W'(cfg_pt);
        cfg_in.pb      = PKG_PAD_W'(cfg_pb);
        cfg_in.pl      = PKG_PAD_W'(cfg_pl);
        cfg_in.pr      = PKG_PAD_W'(cfg_pr);
        cfg_in.pad_val = cfg_pad_val;
        cfg_in.base    = PKG_ADDR_W'(cfg_base);
    end

    assign in_legal = legal_cfg(cfg_in, PE);
    assign launch   = start && (state_q == IDLE) && in_legal;

    // Frame geometry from the latched configuration.
    assign wpp        = CNT_W'(32'(cfg_q.c) / PE);
    assign pw         = CNT_W'(cfg_q.pl) + CNT_W'(cfg_q.w) + CNT_W'(cfg_q.pr);
    assign ph         = CNT_W'(cfg_q.pt) + CNT_W'(cfg_q.h) + CNT_W'(cfg_q.pb);
    assign data_x_beg = CNT_W'(cfg_q.pl);
    assign data_x_end = CNT_W'(cfg_q.pl) + CNT_W'(cfg_q.w);
    assign data_y_end = CNT_W'(cfg_q.pt) + CNT_W'(cfg_q.h);
    assign x_nxt      = x + CNT_W'(1);
    assign y_nxt      = y + CNT_W'(1);
    assign row_start  = (cfg_q.pl != '0) ? ROW_LEFT : ROW_DATA;

    // Pad states write every cycle; the data state only on a transfer.
    assign is_pad   = (state_q == TOP_PAD) || (state_q == ROW_LEFT) ||
                      (state_q == ROW_RIGHT) || (state_q == BOT_PAD);
    assign adv      = is_pad || ((state_q == ROW_DATA) && in_valid);
    assign in_ready = (state_q == ROW_DATA);
    assign busy     = (state_q != IDLE);

    pad_raster_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (launch),
        .adv_i (adv),
        .wpp_i (wpp),
        .pw_i  (pw),
        .ph_i  (ph),
        .x_o   (x),
        .y_o   (y),
        .eog_o (eog),
        .eor_o (eor),
        .eof_o (eof)
    );

    // Next state; zero-width segments are skipped by jumping past them.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    if (cfg_in.pt != '0)      state_d = TOP_PAD;
                    else if (cfg_in.pl != '0) state_d = ROW_LEFT;
                    else                      state_d = ROW_DATA;
                end
            end
            TOP_PAD, ROW_LEFT, ROW_DATA, ROW_RIGHT, BOT_PAD: begin
                if (adv) begin
                    if (eof) begin
                        state_d = IDLE;
                    end else if (eor) begin
                        if (y_nxt < CNT_W'(cfg_q.pt))  state_d = TOP_PAD;
                        else if (y_nxt < data_y_end)   state_d = row_start;
                        else                           state_d = BOT_PAD;
                    end else if (eog) begin
                        if ((state_q == ROW_LEFT) && (x_nxt == data_x_beg))
                            state_d = ROW_DATA;
                        else if ((state_q == ROW_DATA) && (x_nxt == data_x_end))
                            state_d = ROW_RIGHT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, config latch, linear index and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            idx_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            row_done_q <= 1'b0;
            row_idx_q  <= '0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                cfg_q <= cfg_in;
                idx_q <= '0;
            end else if (adv) begin
                idx_q <= idx_q + ADDR_W'(1);
            end
            wr_en_q <= adv;
            if (adv) begin
                wr_addr_q <= ADDR_W'(cfg_q.base) + idx_q;
                wr_data_q <= (state_q == ROW_DATA) ? in_data : {PE{cfg_q.pad_val}};
            end
            row_done_q <= adv && eor;
            if (adv && eor) begin
                row_idx_q <= DIM_W'(y);
            end
            done_q    <= adv && eof;
            cfg_err_q <= start && (state_q == IDLE) && !in_legal;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign row_done = row_done_q;
    assign row_idx  = row_idx_q;
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;

endmodule
